// File: rtl/wowi_pkg.sv
// Shared types and helpers for the word-width adapter memory responder.
package wowi_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned LANES  = 2;
    localparam int unsigned WORD_W = LANE_W * LANES;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_DONE = 3'd2,
        S_WR      = 3'd3,
        S_WR_DONE = 3'd4
    } wowi_state_t;

    // Extract byte lane i of a word.
    function automatic logic [LANE_W-1:0] get_lane(input logic [WORD_W-1:0] w,
                                                   input int unsigned     i);
        return w[i*LANE_W +: LANE_W];
    endfunction

    // Return w with byte lane i replaced by b.
    function automatic logic [WORD_W-1:0] set_lane(input logic [WORD_W-1:0] w,
                                                   input int unsigned     i,
                                                   input logic [LANE_W-1:0] b);
        logic [WORD_W-1:0] r;
        r = w;
        r[i*LANE_W +: LANE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/wowi_mem_responder_byte_ram.sv
// Single-port byte store: synchronous write, combinational read, no reset.
module byte_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Commit one byte per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/wowi_mem_responder.sv
// Responder side of the word-width adapter: serialises level-held word
// read/write commands into one byte access per cycle on a byte-wide store.
module wowi_mem_responder
    import wowi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LANE_W,
    parameter int unsigned WORD_BYTES = LANES,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             st_read,
    input  logic                             st_write,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [DATA_WIDTH*WORD_BYTES-1:0] write_data,
    output logic [DATA_WIDTH*WORD_BYTES-1:0] read_data,
    output logic                             flip_ready,
    output logic                             wrt_done,
    output logic                             busy
);

    localparam int unsigned WORD_BITS = DATA_WIDTH * WORD_BYTES;
    localparam int unsigned CNT_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

    wowi_state_t           state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_BITS-1:0]  wdata_q;
    logic [WORD_BITS-1:0]  rdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  flip_ready_q;
    logic                  wrt_done_q;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  ram_we;
    logic                  last_byte;

    // Byte address wraps naturally in the ADDR_WIDTH-bit add.
    assign ram_addr  = addr_q + ADDR_WIDTH'(cnt_q);
    assign ram_wdata = wdata_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH];
    // Gated by rst_n so a reset edge never commits the next byte.
    assign ram_we    = rst_n && (state_q == S_WR);
    assign last_byte = (cnt_q == LAST_CNT);

    byte_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // Command FSM: accept, walk byte lanes, then hold the handshake until the
    // initiator drops its level-held command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            flip_ready_q <= 1'b0;
            wrt_done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (st_read) begin
                        addr_q  <= base_addr;
                        cnt_q   <= '0;
                        state_q <= S_RD;
                    end else if (st_write) begin
                        addr_q  <= base_addr;
                        wdata_q <= write_data;
                        cnt_q   <= '0;
                        state_q <= S_WR;
                    end
                end
                S_RD: begin
                    rdata_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] <= ram_rdata;
                    if (last_byte) begin
                        cnt_q        <= '0;
                        flip_ready_q <= 1'b1;
                        state_q      <= S_RD_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RD_DONE: begin
                    if (!st_read) begin
                        flip_ready_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                S_WR: begin
                    if (last_byte) begin
                        cnt_q      <= '0;
                        wrt_done_q <= 1'b1;
                        state_q    <= S_WR_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WR_DONE: begin
                    if (!st_write) begin
                        wrt_done_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign read_data  = rdata_q;
    assign flip_ready = flip_ready_q;
    assign wrt_done   = wrt_done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_wowi_mem_responder.sv
// Directed bench for wowi_mem_responder: vector table plus corner sequences.
module tb_wowi_mem_responder;

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [15:0] data;   // write data, or expected read word
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_read = 1'b0;
    logic        st_write = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic [15:0] write_data = 16'h0000;
    logic [15:0] read_data;
    logic        flip_ready;
    logic        wrt_done;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wowi_mem_responder #(
        .DATA_WIDTH(8),
        .WORD_BYTES(2),
        .ADDR_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_read   (st_read),
        .st_write  (st_write),
        .base_addr (base_addr),
        .write_data(write_data),
        .read_data (read_data),
        .flip_ready(flip_ready),
        .wrt_done  (wrt_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Full write handshake; latency counted in edges after acceptance.
    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input string tag);
        int n;
        @(negedge clk);
        base_addr = a; write_data = d; st_write = 1'b1;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!wrt_done && n < 20);
        check({tag, " wr latency"}, 16'(n - 1), 16'd2);
        check({tag, " wr busy"}, 16'(busy), 16'd1);
        st_write = 1'b0;
        @(negedge clk);
        check({tag, " wr done clear"}, 16'({wrt_done, busy}), 16'd0);
    endtask

    // Full read handshake with data and latency checks.
    task automatic do_read(input logic [7:0] a, input logic [15:0] exp, input string tag);
        int n;
        @(negedge clk);
        base_addr = a; st_read = 1'b1;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!flip_ready && n < 20);
        check({tag, " rd latency"}, 16'(n - 1), 16'd2);
        check({tag, " rd data"}, read_data, exp);
        st_read = 1'b0;
        @(negedge clk);
        check({tag, " rd ready clear"}, 16'({flip_ready, busy}), 16'd0);
        check({tag, " rd data hold"}, read_data, exp);
    endtask

    vec_t vecs [12];

    initial begin
        int n;

        vecs[0]  = '{1'b1, 8'h10, 16'hA55A, "t1 wr"};
        vecs[1]  = '{1'b0, 8'h10, 16'hA55A, "t1 rd"};
        vecs[2]  = '{1'b1, 8'h12, 16'h00C3, "t1 nbr"};
        vecs[3]  = '{1'b0, 8'h11, 16'hC3A5, "t1 lanes"};
        vecs[4]  = '{1'b1, 8'hFF, 16'h1234, "t2 wr"};
        vecs[5]  = '{1'b0, 8'hFF, 16'h1234, "t2 rd"};
        vecs[6]  = '{1'b1, 8'h00, 16'h5678, "t2 wr0"};
        vecs[7]  = '{1'b0, 8'hFF, 16'h7834, "t2 wrap"};
        vecs[8]  = '{1'b1, 8'h20, 16'hBEEF, "prep20"};
        vecs[9]  = '{1'b1, 8'h40, 16'h0000, "prep40"};
        vecs[10] = '{1'b1, 8'h80, 16'h7777, "prep80"};
        vecs[11] = '{1'b0, 8'h80, 16'h7777, "rd80"};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rdata", read_data, 16'h0000);
        check("reset flags", 16'({flip_ready, wrt_done, busy}), 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].name);
            else               do_read(vecs[i].addr, vecs[i].data, vecs[i].name);
        end

        // Level hold: ready stays up, no retrigger
        @(negedge clk);
        base_addr = 8'h10; st_read = 1'b1;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!flip_ready && n < 20);
        check("t3 ready", 16'(flip_ready), 16'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3 hold", 16'({flip_ready, busy}), 16'd3);
            check("t3 data", read_data, 16'hA55A);
        end
        st_read = 1'b0;
        @(negedge clk);
        check("t3 release", 16'({flip_ready, busy}), 16'd0);

        // Simultaneous read/write: read wins, write follows
        @(negedge clk);
        base_addr = 8'h20; write_data = 16'h0F0F; st_read = 1'b1; st_write = 1'b1;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!flip_ready && n < 20);
        check("t4 rd first", read_data, 16'hBEEF);
        check("t4 no wr yet", 16'(wrt_done), 16'd0);
        st_read = 1'b0;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!wrt_done && n < 20);
        check("t4 wr edges", 16'(n), 16'd4);
        st_write = 1'b0;
        @(negedge clk);
        do_read(8'h20, 16'h0F0F, "t4 verify");

        // Reset mid-write, command dropped: only byte 0 committed
        @(negedge clk);
        base_addr = 8'h40; write_data = 16'hCAFE; st_write = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; st_write = 1'b0;
        @(negedge clk);
        check("t5 rst flags", 16'({flip_ready, wrt_done, busy}), 16'd0);
        check("t5 rst rdata", read_data, 16'h0000);
        rst_n = 1'b1;
        do_read(8'h40, 16'h00FE, "t5 partial");

        // Reset mid-write, command held: restarts from byte 0
        @(negedge clk);
        base_addr = 8'h40; write_data = 16'hCAFE; st_write = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5b no done", 16'({wrt_done, busy}), 16'd0);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!wrt_done && n < 20);
        check("t5b restart edges", 16'(n), 16'd3);
        st_write = 1'b0;
        @(negedge clk);
        do_read(8'h40, 16'hCAFE, "t5b verify");

        // Busy ignore: address/write changes mid-read have no effect
        @(negedge clk);
        base_addr = 8'h10; st_read = 1'b1;
        @(negedge clk);
        base_addr = 8'h80; write_data = 16'h1111; st_write = 1'b1;
        @(negedge clk);
        st_write = 1'b0;
        n = 0;
        while (!flip_ready && n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
        end
        check("t6 rd data", read_data, 16'hA55A);
        st_read = 1'b0;
        @(negedge clk);
        do_read(8'h80, 16'h7777, "t6 no wr");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
